// File: rtl/ic_pkg.sv
// ic_pkg: shared FSM encoding and sizing helper for the global FIFO controller.
package ic_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ic_rr_arbiter.sv
// ic_rr_arbiter: round-robin grant over N requesters; pointer advances past each grant.
module ic_rr_arbiter
    import ic_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o
);

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [2*N-1:0] rot;
    logic [PW:0]    sum;
    logic           found;

    // Rotate so bit 0 is the requester at the pointer; the lowest set bit wins.
    always_comb begin
        rot   = {req_i, req_i} >> ptr_q;
        found = 1'b0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (PW+1)'(k);
            end
        end
        gnt_idx_o = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
        gnt_o     = (en_i && found) ? (N'(1) << gnt_idx_o) : '0;
        ptr_d     = (en_i && found) ? ((gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ic_global_ff_ctrl.sv
// ic_global_ff_ctrl: arbitrates producers onto the global FIFO, streams its output
// through a 2-entry register buffer, sequences flushes and tracks occupancy.
module ic_global_ff_ctrl
    import ic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      fifo_wrreq,
    output logic                      fifo_rdreq,
    output logic                      fifo_sclr,
    input  logic [DATA_W-1:0]         fifo_q,
    input  logic                      fifo_empty,
    input  logic                      fifo_full,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          level
);

    localparam int PW = ptr_w(NUM_REQ);

    state_t             state_q, state_d;
    logic               run, wr, pop;
    logic [PW-1:0]      gidx;
    logic [DATA_W-1:0]  buf_q [2];
    logic               wp_q, rp_q, inflight_q;
    logic [1:0]         cnt_q, cnt_d, credit;
    logic [CNT_W-1:0]   level_q, level_d;

    assign run = (state_q == S_RUN);

    ic_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .req_i     (req_valid),
        .en_i      (run && !fifo_full),
        .gnt_o     (req_ready),
        .gnt_idx_o (gidx)
    );

    always_comb begin
        state_d = (state_q == S_FLUSH) ? S_DONE :
                  (state_q == S_DONE)  ? S_RUN  :
                  (flush ? S_FLUSH : S_RUN);
        wr = |req_ready;
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) fifo_data = req_data[i*DATA_W +: DATA_W];
        end
        pop = out_valid && out_ready;
        // Credit counts buffer slots already spoken for, including a read still in flight.
        credit = cnt_q + {1'b0, inflight_q};
        fifo_rdreq = run && !fifo_empty && (credit < 2'd2 || (credit == 2'd2 && pop));
        cnt_d = fifo_sclr ? '0 : cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        level_d = fifo_sclr ? '0 :
                  level_q + CNT_W'(wr && level_q != CNT_W'(DEPTH + 2)) - CNT_W'(pop);
    end

    assign fifo_wrreq = wr;
    assign fifo_sclr  = (state_q == S_FLUSH);
    assign flush_done = (state_q == S_DONE);
    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = buf_q[rp_q];
    assign level      = level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            level_q    <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rdreq;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            if (fifo_sclr) begin
                wp_q <= 1'b0;
                rp_q <= 1'b0;
            end else begin
                if (inflight_q) begin
                    buf_q[wp_q] <= fifo_q;
                    wp_q        <= ~wp_q;
                end
                if (pop) rp_q <= ~rp_q;
            end
        end
    end

endmodule

// File: tb/tb_ic_global_ff_ctrl.sv
// tb_ic_global_ff_ctrl: FIFO environment model plus scoreboard reference for the controller.
module tb_ic_global_ff_ctrl;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int CW = 5;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           flush = 1'b0;
    logic           flush_done;
    logic [W-1:0]   fifo_data;
    logic           fifo_wrreq, fifo_rdreq, fifo_sclr;
    logic [W-1:0]   fifo_q = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_full = 1'b0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b0;
    logic [CW-1:0]  level;

    ic_global_ff_ctrl #(.NUM_REQ(N), .DATA_W(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .flush_done(flush_done), .fifo_data(fifo_data),
        .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .level(level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] fq[$];
    logic [W-1:0] sb[$];
    int           mptr = 0, mode = 0, cyc = 0, popped = 0, first_wr = -1, first_ov = -1;
    logic [N-1:0] gl = '0;
    logic         pv_hold = 1'b0, last_rd = 1'b0, last_sclr = 1'b0, last_done = 1'b0;
    logic [W-1:0] pv_data = '0;

    task automatic chk_reset(input string t);
        chk({t, "_rdy"}, 64'(req_ready), 0);
        chk({t, "_wr"}, 64'(fifo_wrreq), 0);
        chk({t, "_rd"}, 64'(fifo_rdreq), 0);
        chk({t, "_sclr"}, 64'(fifo_sclr), 0);
        chk({t, "_done"}, 64'(flush_done), 0);
        chk({t, "_ov"}, 64'(out_valid), 0);
        chk({t, "_od"}, 64'(out_data), 0);
        chk({t, "_lvl"}, 64'(level), 0);
    endtask

    // One clock: check at the falling edge, advance the reference, then update the FIFO model.
    task automatic cycle();
        logic [N-1:0] eg;
        logic [W-1:0] wd;
        logic         do_wr, do_rd, do_sclr;
        int           g;
        @(negedge clock);
        chk("lvl", 64'(level), 64'(sb.size()));
        chk("sclr", 64'(fifo_sclr), 64'(mode == 1));
        chk("done", 64'(flush_done), 64'(mode == 2));
        chk("ovf", 64'(fifo_wrreq & fifo_full), 0);
        chk("udf", 64'(fifo_rdreq & fifo_empty), 0);
        if (sb.size() == 0) chk("oval", 64'(out_valid), 0);
        if (pv_hold && out_valid) chk("stable", 64'(out_data), 64'(pv_data));
        g = -1;
        if (mode == 0 && reset_n && !fifo_full)
            for (int k = 0; k < N; k++)
                if (g < 0 && ((req_valid >> ((mptr + k) % N)) & 1) != 0) g = (mptr + k) % N;
        eg = (g >= 0) ? (N'(1) << g) : '0;
        chk("gnt", 64'(req_ready), 64'(eg));
        chk("wrreq", 64'(fifo_wrreq), 64'(g >= 0));
        wd = '0;
        if (g >= 0) begin
            wd = W'(req_data >> (g * W));
            chk("wdat", 64'(fifo_data), 64'(wd));
            mptr = (g + 1) % N;
            if (first_wr < 0) first_wr = cyc;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("pop_empty", 64'(out_valid), 0);
            else begin
                chk("odat", 64'(out_data), 64'(sb.pop_front()));
                popped++;
            end
        end
        if (g >= 0) sb.push_back(wd);
        if (mode == 1) sb.delete();
        pv_hold = out_valid & !out_ready;
        pv_data = out_data;
        mode = !reset_n ? 0 : (mode == 0) ? (flush ? 1 : 0) : (mode == 1) ? 2 : 0;
        gl = req_ready;
        do_wr = fifo_wrreq;
        do_rd = fifo_rdreq;
        do_sclr = fifo_sclr;
        last_rd = fifo_rdreq;
        last_sclr = fifo_sclr;
        last_done = flush_done;
        wd = fifo_data;
        @(posedge clock);
        #1;
        cyc++;
        if (do_sclr) fq.delete();
        else begin
            if (do_rd && fq.size() > 0) fifo_q = fq.pop_front();
            if (do_wr && fq.size() < D) fq.push_back(wd);
        end
        fifo_empty = (fq.size() == 0);
        fifo_full = (fq.size() == D);
    endtask

    initial begin
        int v, n, k, p0;
        #1;
        chk_reset("rst0");
        repeat (2) cycle();
        reset_n = 1'b1;

        // single producer, consumer always ready
        out_ready = 1'b1;
        v = 1; k = 0; popped = 0; first_wr = -1; first_ov = -1;
        while (v <= 16 && k < 100) begin
            req_valid = 4'b0001;
            req_data[W-1:0] = W'(v);
            cycle();
            if (gl[0]) v++;
            k++;
        end
        req_valid = '0;
        chk("t1_sent", 64'(v), 17);
        repeat (8) cycle();
        chk("t1_lat", 64'(first_ov - first_wr), 3);
        chk("t1_cnt", 64'(popped), 16);
        chk("t1_lvl", 64'(level), 0);

        // all ports valid, consumer stalled: fill to full
        out_ready = 1'b0;
        req_valid = 4'hF;
        repeat (30) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        chk("t2_lvl", 64'(level), 18);
        chk("t2_rdy", 64'(req_ready), 0);
        req_valid = '0;

        // drain from full with a 1-on / 2-off ready pattern
        for (int i = 0; i < 60; i++) begin
            out_ready = (i % 3 == 0);
            cycle();
        end
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("t3_lvl", 64'(level), 0);

        // flush with 10 words queued and a read in flight
        out_ready = 1'b0;
        n = 0; k = 0;
        while (n < 10 && k < 50) begin
            req_valid = 4'b0001;
            req_data[W-1:0] = 32'hA000_0000 + W'(n);
            cycle();
            if (gl[0]) n++;
            k++;
        end
        req_valid = '0;
        chk("t4_q", 64'(n), 10);
        chk("t4_lvl10", 64'(level), 10);
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("t4_rdfl", 64'(last_rd), 1);
        flush = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("t4_sclr", 64'(last_sclr), 1);
        cycle();
        chk("t4_done", 64'(last_done), 1);
        chk("t4_lvl", 64'(level), 0);
        chk("t4_ov", 64'(out_valid), 0);
        p0 = popped;
        out_ready = 1'b1;
        n = 0; k = 0;
        while (n < 5 && k < 30) begin
            req_valid = 4'b0100;
            req_data[2*W +: W] = 32'hB000_0000 + W'(n);
            cycle();
            if (gl[2]) n++;
            k++;
        end
        req_valid = '0;
        repeat (6) cycle();
        chk("t4_post", 64'(popped - p0), 5);

        // ports 1 and 3 with the pointer at 2
        req_valid = 4'b0010;
        cycle();
        chk("t5_pre", 64'(gl), 64'(4'b0010));
        req_valid = 4'b1010;
        cycle();
        chk("t5_a", 64'(gl), 64'(4'b1000));
        cycle();
        chk("t5_b", 64'(gl), 64'(4'b0010));
        req_valid = '0;

        // random traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            req_valid = N'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush = 1'b0;

        // reset in the middle of a flush
        req_valid = 4'hF;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #2;
        reset_n = 1'b0;
        req_valid = '0;
        fq.delete();
        fifo_empty = 1'b1;
        fifo_full = 1'b0;
        sb.delete();
        mode = 0;
        mptr = 0;
        pv_hold = 1'b0;
        #1;
        chk_reset("rst1");
        repeat (3) cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            req_valid = N'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 1) == 1;
            cycle();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (25) cycle();
        chk("end_lvl", 64'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ic_global_ff_ctrl.md
# ic_global_ff_ctrl

Controller that sits in front of the 32-bit × 16-word global interface FIFO. It round-robin arbitrates several producer ports onto the FIFO's single write port and turns the FIFO's non-showahead read port into a registered valid/ready output stream. It also sequences FIFO flushes through the synchronous clear and keeps a shadow occupancy count for status and debug.

## Interface
- NUM_REQ, 4: number of producer ports (2..8)
- DATA_W, 32: word width; must match the FIFO width
- DEPTH, 16: FIFO depth in words
- CNT_W, 5: occupancy counter width, equal to clog2(DEPTH)+1
- clock  in  1  single clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  producer i offers a word
- req_data  in  NUM_REQ*DATA_W  producer i data in slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero; word i is accepted this cycle
- flush  in  1  single-cycle request to discard all FIFO and buffered data
- flush_done  out  1  single-cycle pulse when the flush has completed
- fifo_data  out  DATA_W  to FIFO data
- fifo_wrreq  out  1  to FIFO wrreq
- fifo_rdreq  out  1  to FIFO rdreq
- fifo_sclr  out  1  to FIFO sclr
- fifo_q  in  DATA_W  from FIFO q; valid the cycle after rdreq
- fifo_empty, fifo_full  in  1 each  FIFO status flags
- out_valid  out  1  output word available
- out_data  out  DATA_W  output word
- out_ready  in  1  consumer accepts the word when valid and ready are both high
- level  out  CNT_W  words in the FIFO plus words in the output buffer

## Operation
- FSM states are S_RUN, S_FLUSH and S_DONE. Reset enters S_RUN.
- S_RUN with flush=1 moves to S_FLUSH. S_FLUSH always moves to S_DONE. S_DONE always moves to S_RUN.
- In S_FLUSH, fifo_sclr=1 for exactly that one cycle. The output buffer is emptied, the in-flight read flag is cleared, and level is set to 0.
- flush_done=1 in S_DONE.
- A flush that arrives while in S_FLUSH or S_DONE is ignored.
- Write arbitration happens only in S_RUN with fifo_full=0:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - The grant drives req_ready[g]=1, fifo_wrreq=1 and fifo_data=req_data[g].
  - rr_ptr moves to (g+1) mod NUM_REQ on each grant. It is unchanged when there is no grant.
- req_ready is combinational from req_valid, fifo_full and the state. Producers must not make req_valid depend on req_ready.
- A flush asserted in S_RUN does not block writes in that same cycle. The sclr in the next cycle discards those words.
- The output buffer is a 2-entry FIFO made of registers. out_valid and out_data come from its head.
- Read issue:
  - Define credit = buf_cnt + rd_inflight.
  - fifo_rdreq = S_RUN & !fifo_empty & (credit<2 | (credit==2 & out_valid & out_ready)).
  - rd_inflight is registered from fifo_rdreq. When rd_inflight=1, fifo_q is pushed into the buffer.
- The buffer supports push and pop in the same cycle, with no change to buf_cnt.
- level update per cycle:
  - +1 on a write.
  - -1 on a pop (out_valid & out_ready).
  - Simultaneous write and pop leave level unchanged.
  - S_FLUSH forces 0, overriding everything.
  - level never exceeds DEPTH+2.
- The controller never writes while fifo_full=1 and never reads while fifo_empty=1, so the FIFO's overflow and underflow checks never fire.

## Timing
- Reset values: req_ready=0, fifo_wrreq=0, fifo_rdreq=0, fifo_sclr=0, flush_done=0, out_valid=0, out_data=0, level=0, rr_ptr=0, state S_RUN.
- Write path has zero latency: the word is accepted and written in the same cycle.
- Read latency: rdreq at cycle t, data captured at the t+1 edge, out_valid=1 from cycle t+2.
- A word written into an empty FIFO at cycle t gives out_valid=1 at t+3.
- Steady-state throughput is 1 word per cycle with out_ready held high.
- Flush: flush at cycle t, sclr at t+1, flush_done at t+2, and new writes accepted from t+3.
- Async reset during a flush returns to S_RUN without an sclr pulse.

## Structure
- The FSM state encoding and the rr_ptr width function belong in a shared package, ic_pkg.
- One sub-module is natural: ic_rr_arbiter (NUM_REQ-wide round-robin grant with a pointer-update input). The read side and FSM stay inline.

## Test plan
- Single producer: port 0 writes 0x00000001..0x00000010 with out_ready=1. Required: 16 words out in order, first out_valid 3 cycles after the first write, level returns to 0.
- All 4 ports valid continuously, out_ready=0. Required: grants in the order 0,1,2,3,0,… Required: writes stop at fifo_full with level=16+2=18 and req_ready all 0.
- From the full state, toggle out_ready=1 for 1 cycle, then 0 for 2 cycles, repeating. Required: no word lost or duplicated, out_data stable while out_valid & !out_ready.
- Flush with 10 words queued and a read in flight. Required: sclr pulse 1 cycle later, flush_done 2 cycles later, out_valid=0, level=0, and only post-flush words appear afterwards.
- Ports 1 and 3 valid with rr_ptr=2. Required: port 3 granted first, then port 1.
- Assert reset_n low mid-stream. Required: all outputs immediately at their reset values; normal operation after release.
